// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop process the operands
// LSB-first, one bit per clock, with a Start/Busy/Done handshake.
module serial_adder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  input  logic                  Carry_In,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Sum_Out,
  output logic                  Carry_Out
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic [DATA_WIDTH-2:0] sum_r;
  logic                  carry_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  busy_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] sum_out_r;
  logic                  carry_out_r;

  logic                  fa_sum_s;
  logic                  fa_carry_s;
  logic [DATA_WIDTH-1:0] sum_cat_s;
  logic                  last_bit_s;

  assign fa_sum_s   = a_r[0] ^ b_r[0] ^ carry_r;
  assign fa_carry_s = (a_r[0] & b_r[0]) | (a_r[0] & carry_r) | (b_r[0] & carry_r);
  // The final sum bit lands in the MSB; the earlier bits are already in sum_r.
  assign sum_cat_s  = {fa_sum_s, sum_r};
  assign last_bit_s = (state_r == SHIFT) && (cnt_r == LAST_BIT);

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_BIT) begin
          next_state_s = DONE;
        end else begin
          next_state_s = SHIFT;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand load and bit-serial datapath.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      a_r     <= {DATA_WIDTH{1'b0}};
      b_r     <= {DATA_WIDTH{1'b0}};
      sum_r   <= {(DATA_WIDTH-1){1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (Start) begin
            a_r     <= Data_A_In;
            b_r     <= Data_B_In;
            carry_r <= Carry_In;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        SHIFT: begin
          a_r     <= a_r >> 1;
          b_r     <= b_r >> 1;
          sum_r   <= sum_cat_s[DATA_WIDTH-1:1];
          carry_r <= fa_carry_s;
          cnt_r   <= cnt_r + CNT_W'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered handshake and result; the result only moves on the final bit.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sum_out_r   <= {DATA_WIDTH{1'b0}};
      carry_out_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s == SHIFT);
      done_r <= (next_state_s == DONE);
      if (last_bit_s) begin
        sum_out_r   <= sum_cat_s;
        carry_out_r <= fa_carry_s;
      end
    end
  end

  assign Busy      = busy_r;
  assign Done      = done_r;
  assign Sum_Out   = sum_out_r;
  assign Carry_Out = carry_out_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: 8- and 16-bit instances driven in lockstep, checked
// against an arithmetic reference each cycle.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  serial_adder #(.DATA_WIDTH(8)) dut8 (
    .Clock(clk), .Reset_n(rst_n), .Start(start),
    .Data_A_In(a[7:0]), .Data_B_In(b[7:0]), .Carry_In(cin),
    .Busy(busy8), .Done(done8), .Sum_Out(sum8), .Carry_Out(cout8)
  );

  serial_adder #(.DATA_WIDTH(16)) dut16 (
    .Clock(clk), .Reset_n(rst_n), .Start(start),
    .Data_A_In(a), .Data_B_In(b), .Carry_In(cin),
    .Busy(busy16), .Done(done16), .Sum_Out(sum16), .Carry_Out(cout16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] add8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 9'(c);
  endfunction

  function automatic logic [16:0] add16(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 17'(c);
  endfunction

  // Present a request for one cycle; operands become garbage afterwards.
  task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic c);
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y; cin = c;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
  endtask

  // Follow both instances cycle by cycle after the accepting edge.
  task automatic run_both(input logic [15:0] x, input logic [15:0] y, input logic c,
                          input int glitch_cyc);
    logic [8:0]  e8;
    logic [16:0] e16;
    e8  = add8(x[7:0], y[7:0], c);
    e16 = add16(x, y, c);
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clk);
      check_eq("busy8",  32'(busy8),  32'(cyc <= 8));
      check_eq("done8",  32'(done8),  32'(cyc == 9));
      check_eq("busy16", 32'(busy16), 32'(cyc <= 16));
      check_eq("done16", 32'(done16), 32'(cyc == 17));
      if (cyc >= 9)  check_eq("res8",  32'({cout8, sum8}),   32'(e8));
      if (cyc == 17) check_eq("res16", 32'({cout16, sum16}), 32'(e16));
      if (cyc == glitch_cyc) begin
        start = 1'b1; a = 16'h00AA; b = 16'h0055;
      end
      if (cyc == glitch_cyc + 1) start = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] rx, ry;
    logic        rc;
    rst_n = 1'b0; start = 1'b0; cin = 1'b0; a = 16'h0000; b = 16'h0000;
    #12;
    check_eq("rst_busy8", 32'(busy8), 32'd0);
    check_eq("rst_done8", 32'(done8), 32'd0);
    check_eq("rst_res8",  32'({cout8, sum8}), 32'd0);
    check_eq("rst_res16", 32'({cout16, sum16}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    launch(16'h000F, 16'h0001, 1'b0); run_both(16'h000F, 16'h0001, 1'b0, -1);
    launch(16'h00FF, 16'h0001, 1'b0); run_both(16'h00FF, 16'h0001, 1'b0, -1);
    launch(16'h00FF, 16'h00FF, 1'b1); run_both(16'h00FF, 16'h00FF, 1'b1, -1);
    launch(16'hFFFF, 16'h0001, 1'b0); run_both(16'hFFFF, 16'h0001, 1'b0, -1);
    launch(16'h0012, 16'h0034, 1'b0); run_both(16'h0012, 16'h0034, 1'b0, 3);

    // Asynchronous reset four cycles into SHIFT.
    launch(16'h003C, 16'h005A, 1'b1);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      check_eq("pre_rst_busy8", 32'(busy8), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy8",  32'(busy8),  32'd0);
    check_eq("arst_done8",  32'(done8),  32'd0);
    check_eq("arst_res8",   32'({cout8, sum8}), 32'd0);
    check_eq("arst_busy16", 32'(busy16), 32'd0);
    check_eq("arst_res16",  32'({cout16, sum16}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      check_eq("idle_busy8",  32'(busy8),  32'd0);
      check_eq("idle_done8",  32'(done8),  32'd0);
      check_eq("idle_done16", 32'(done16), 32'd0);
      check_eq("idle_res8",   32'({cout8, sum8}), 32'd0);
    end

    // Start held high: back-to-back operations on the 8-bit instance.
    @(posedge clk); #1;
    start = 1'b1; a = 16'h0080; b = 16'h0080; cin = 1'b0;
    @(posedge clk); #1;
    a = 16'h007F; b = 16'h0001; cin = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      check_eq("b2b_done8", 32'(done8), 32'(cyc == 9 || cyc == 19));
      check_eq("b2b_busy8", 32'(busy8), 32'((cyc <= 8) || (cyc >= 11 && cyc <= 18)));
      if (cyc >= 9 && cyc <= 18) check_eq("b2b_res8_1", 32'({cout8, sum8}), 32'(add8(8'h80, 8'h80, 1'b0)));
      if (cyc == 19) check_eq("b2b_res8_2", 32'({cout8, sum8}), 32'(add8(8'h7F, 8'h01, 1'b1)));
      if (cyc == 17) check_eq("b2b_res16", 32'({cout16, sum16}), 32'(add16(16'h0080, 16'h0080, 1'b0)));
      if (cyc == 19) start = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int n = 0; n < 1000; n++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 1'($urandom);
      launch(rx, ry, rc);
      run_both(rx, ry, rc, -1);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
